// File: rtl/bcd_ctrl_pkg.sv
// Shared definitions for the BCD counter controller: FSM state encoding,
// the largest legal BCD digit, and the digit sanitising helper.
package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Replace a non-BCD nibble (A-F) with a caller-chosen fill digit.
  function automatic logic [3:0] sanitise_digit(input logic [3:0] d,
                                                input logic [3:0] fill);
    return (d > BCD_MAX) ? fill : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One synchronous mod-10 digit. Load has priority over increment; the carry
// out is combinational so a whole cascade ripples within one clock.
module bcd_digit
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry_out
);

  assign carry_out = inc & (q == BCD_MAX);

  // Digit register: clear, load, or advance with wrap 9 -> 0.
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    if (!clr) begin
      q <= 4'd0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= (q == BCD_MAX) ? 4'd0 : q + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Controller for a cascade of BCD digit counters: start/stop/load command
// decode, tick-paced stepping, programmable terminal count with wrap or halt.
module bcd_count_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                cmd_start,
  input  logic                cmd_stop,
  input  logic                cmd_load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic [4*DIGITS-1:0] limit,
  input  logic                tick_en,
  output logic [4*DIGITS-1:0] count,
  output logic                running,
  output logic                done,
  output logic                tc
);

  localparam int W = 4 * DIGITS;

  state_t         state, state_nxt;
  logic [W-1:0]   limit_s, load_s, inc_val;
  logic [DIGITS:0] nines;   // nines[i]: all digits below i are 9
  logic [DIGITS:0] carry;   // increment enable rippling up the cascade
  logic           do_load, do_zero, do_step, tc_nxt, reload_hit;

  // Sanitise presets (bad digit -> 0) and the limit (bad digit -> 9).
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      load_s[4*i +: 4]  = sanitise_digit(load_val[4*i +: 4], 4'd0);
      limit_s[4*i +: 4] = sanitise_digit(limit[4*i +: 4], BCD_MAX);
    end
  end

  // The value count would take after one step, used for the terminal compare.
  assign nines[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_inc
    assign nines[i+1] = nines[i] & (count[4*i +: 4] == BCD_MAX);
    assign inc_val[4*i +: 4] = !nines[i]                     ? count[4*i +: 4] :
                               (count[4*i +: 4] == BCD_MAX) ? 4'd0 :
                                                              count[4*i +: 4] + 4'd1;
  end

  // With auto-reload, a step taken while sitting on a nonzero limit returns to 0.
  assign reload_hit = (AUTO_RELOAD != 0) && (count == limit_s) && (limit_s != '0);

  // Command decode and next-state selection; load > stop > start.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt = state;
    do_load   = 1'b0;
    do_zero   = 1'b0;
    do_step   = 1'b0;
    tc_nxt    = 1'b0;
    if (cmd_load) begin
      do_load   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: begin
          if (!cmd_stop && cmd_start) state_nxt = RUN;
        end
        RUN: begin
          if (cmd_stop) begin
            state_nxt = PAUSE;
          end else if (tick_en) begin
            if (reload_hit) begin
              do_zero = 1'b1;
            end else begin
              do_step = 1'b1;
              if (inc_val == limit_s) begin
                tc_nxt = 1'b1;
                if (AUTO_RELOAD == 0) state_nxt = DONE;
              end
            end
          end
        end
        DONE: begin
          if (!cmd_stop && cmd_start) begin
            do_zero   = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign carry[0] = do_step;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .clr       (clr),
      .ld        (do_load | do_zero),
      .ld_val    (do_load ? load_s[4*i +: 4] : 4'd0),
      .inc       (carry[i]),
      .q         (count[4*i +: 4]),
      .carry_out (carry[i+1])
    );
  end

  // State and registered status flags.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
      tc      <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == RUN);
      done    <= (state_nxt == DONE);
      tc      <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Self-checking bench: directed scenarios plus randomized traffic compared
// against a decimal-integer reference model, for both reload modes at once.
module tb_bcd_count_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic        clk = 1'b0;
  logic        clr;
  logic        cmd_start, cmd_stop, cmd_load, tick_en;
  logic [15:0] load_val, limit;
  logic [15:0] count0, count1;
  logic        running0, running1, done0, done1, tc0, tc1;

  int checks = 0;
  int errors = 0;

  // Reference model state, index 0: halt mode, index 1: auto-reload mode.
  int m_cnt[2];
  int m_st[2];
  bit m_tc[2];

  always #5 clk = ~clk;

  bcd_count_ctrl #(.DIGITS(4), .AUTO_RELOAD(0)) dut0 (
    .clk(clk), .clr(clr), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_load(cmd_load), .load_val(load_val), .limit(limit), .tick_en(tick_en),
    .count(count0), .running(running0), .done(done0), .tc(tc0)
  );

  bcd_count_ctrl #(.DIGITS(4), .AUTO_RELOAD(1)) dut1 (
    .clk(clk), .clr(clr), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_load(cmd_load), .load_val(load_val), .limit(limit), .tick_en(tick_en),
    .count(count1), .running(running1), .done(done1), .tc(tc1)
  );

  function automatic int bcd_to_int(input logic [15:0] v, input int fill);
    int n = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(v[4*i +: 4]);
      n = n * 10 + ((d > 9) ? fill : d);
    end
    return n;
  endfunction

  function automatic logic [15:0] int_to_bcd(input int n);
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_st[k] = M_IDLE; m_tc[k] = 0;
    end
  endtask

  // Apply one clock edge of the specified behaviour in decimal arithmetic.
  task automatic model_edge();
    int lim = bcd_to_int(limit, 9);
    for (int k = 0; k < 2; k++) begin
      m_tc[k] = 0;
      if (cmd_load) begin
        m_cnt[k] = bcd_to_int(load_val, 0);
        m_st[k]  = M_IDLE;
      end else if (m_st[k] == M_RUN) begin
        if (cmd_stop) m_st[k] = M_PAUSE;
        else if (tick_en) begin
          if (k == 1 && m_cnt[k] == lim && lim != 0) m_cnt[k] = 0;
          else begin
            m_cnt[k] = (m_cnt[k] + 1) % 10000;
            if (m_cnt[k] == lim) begin
              m_tc[k] = 1;
              if (k == 0) m_st[k] = M_DONE;
            end
          end
        end
      end else if (!cmd_stop && cmd_start) begin
        if (m_st[k] == M_DONE) m_cnt[k] = 0;
        m_st[k] = M_RUN;
      end
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    cmd_start = 0; cmd_stop = 0; cmd_load = 0; tick_en = 0;
  endtask

  task automatic load_and_start(input logic [15:0] v);
    idle_inputs(); cmd_load = 1; load_val = v; step_clk();
    cmd_load = 0; cmd_start = 1; step_clk();
    cmd_start = 0;
  endtask

  task automatic test_reset();
    clr = 0; idle_inputs(); load_val = '0; limit = 16'h9999;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({count0, running0, done0, tc0} !== 19'h0) begin
      errors++; $display("FAIL reset_initial: got %h/%b%b%b want 0000/000", count0, running0, done0, tc0);
    end
    clr = 1;
    load_and_start(16'h0457);
    step_clk();
    checks++;
    if (count0 !== 16'h0457 || running0 !== 1'b1) begin
      errors++; $display("FAIL reset_prerun: got %h run=%b want 0457 run=1", count0, running0);
    end
    #2 clr = 0;
    model_reset();
    #1;
    checks++;
    if ({count0, running0, done0, tc0, count1, running1, done1, tc1} !== 38'h0) begin
      errors++; $display("FAIL reset_async: got %h/%b%b%b %h/%b%b%b want all zero",
                         count0, running0, done0, tc0, count1, running1, done1, tc1);
    end
    clr = 1;
  endtask

  task automatic test_cascade();
    limit = 16'h9999;
    load_and_start(16'h0999);
    tick_en = 1; step_clk(); tick_en = 0;
    checks++;
    if (count0 !== 16'h1000 || count1 !== 16'h1000) begin
      errors++; $display("FAIL cascade_carry: got %h %h want 1000", count0, count1);
    end
    limit = 16'h5000;
    load_and_start(16'h9999);
    tick_en = 1; step_clk(); tick_en = 0;
    checks++;
    if (count0 !== 16'h0000 || tc0 !== 1'b0 || count1 !== 16'h0000 || tc1 !== 1'b0) begin
      errors++; $display("FAIL cascade_wrap: got %h tc=%b %h tc=%b want 0000 tc=0", count0, tc0, count1, tc1);
    end
  endtask

  task automatic test_terminal_halt();
    limit = 16'h0012;
    load_and_start(16'h0000);
    tick_en = 1;
    repeat (11) step_clk();
    checks++;
    if (count0 !== 16'h0011 || tc0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL halt_pre: got %h tc=%b done=%b want 0011 tc=0 done=0", count0, tc0, done0);
    end
    step_clk();
    checks++;
    if (count0 !== 16'h0012 || tc0 !== 1'b1 || done0 !== 1'b1 || running0 !== 1'b0) begin
      errors++; $display("FAIL halt_hit: got %h tc=%b done=%b run=%b want 0012 tc=1 done=1 run=0",
                         count0, tc0, done0, running0);
    end
    repeat (3) step_clk();
    checks++;
    if (count0 !== 16'h0012 || tc0 !== 1'b0 || done0 !== 1'b1) begin
      errors++; $display("FAIL halt_hold: got %h tc=%b done=%b want 0012 tc=0 done=1", count0, tc0, done0);
    end
    tick_en = 0; cmd_start = 1; step_clk(); cmd_start = 0;
    checks++;
    if (count0 !== 16'h0000 || running0 !== 1'b1 || done0 !== 1'b0) begin
      errors++; $display("FAIL halt_restart: got %h run=%b done=%b want 0000 run=1 done=0", count0, running0, done0);
    end
  endtask

  task automatic test_terminal_reload();
    logic [15:0] exp_c[8] = '{16'h1, 16'h2, 16'h3, 16'h0, 16'h1, 16'h2, 16'h3, 16'h0};
    bit          exp_t[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    limit = 16'h0003;
    load_and_start(16'h0000);
    tick_en = 1;
    for (int i = 0; i < 8; i++) begin
      step_clk();
      checks++;
      if (count1 !== exp_c[i] || tc1 !== exp_t[i] || running1 !== 1'b1) begin
        errors++; $display("FAIL reload_seq[%0d]: got %h tc=%b run=%b want %h tc=%b run=1",
                           i, count1, tc1, running1, exp_c[i], exp_t[i]);
      end
    end
    tick_en = 0;
  endtask

  task automatic test_priority_pause();
    limit = 16'h9999;
    idle_inputs(); cmd_load = 1; cmd_stop = 1; cmd_start = 1; load_val = 16'h00A5;
    step_clk(); idle_inputs();
    checks++;
    if (count0 !== 16'h0005 || running0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL prio_load: got %h run=%b done=%b want 0005 run=0 done=0", count0, running0, done0);
    end
    cmd_start = 1; step_clk(); cmd_start = 0;
    tick_en = 1; step_clk();
    cmd_stop = 1; step_clk(); cmd_stop = 0; tick_en = 0;
    checks++;
    if (count0 !== 16'h0006 || running0 !== 1'b0) begin
      errors++; $display("FAIL pause_hold: got %h run=%b want 0006 run=0", count0, running0);
    end
    cmd_start = 1; step_clk(); cmd_start = 0;
    tick_en = 1; step_clk(); tick_en = 0;
    checks++;
    if (count0 !== 16'h0007 || running0 !== 1'b1) begin
      errors++; $display("FAIL pause_resume: got %h run=%b want 0007 run=1", count0, running0);
    end
  endtask

  task automatic test_tick_gating();
    limit = 16'h9999;
    load_and_start(16'h0000);
    for (int i = 0; i < 30; i++) begin
      tick_en = (i % 3 == 0);
      step_clk();
    end
    tick_en = 0;
    checks++;
    if (count0 !== 16'h0010 || count1 !== 16'h0010) begin
      errors++; $display("FAIL tick_gating: got %h %h want 0010", count0, count1);
    end
  endtask

  task automatic test_random();
    logic [18:0] got, want;
    for (int n = 0; n < 1500; n++) begin
      cmd_load  = ($urandom_range(0, 39) == 0);
      cmd_stop  = ($urandom_range(0, 15) == 0);
      cmd_start = ($urandom_range(0, 3) == 0);
      tick_en   = ($urandom_range(0, 2) != 0);
      load_val  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : int_to_bcd($urandom_range(0, 30));
      if ($urandom_range(0, 29) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 16'($urandom) : int_to_bcd($urandom_range(0, 25));
      step_clk();
      got  = {count0, running0, done0, tc0};
      want = {int_to_bcd(m_cnt[0]), m_st[0] == M_RUN, m_st[0] == M_DONE, m_tc[0]};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random_halt[%0d]: got %h want %h", n, got, want);
      end
      got  = {count1, running1, done1, tc1};
      want = {int_to_bcd(m_cnt[1]), m_st[1] == M_RUN, m_st[1] == M_DONE, m_tc[1]};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random_reload[%0d]: got %h want %h", n, got, want);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_cascade();
    test_terminal_halt();
    test_terminal_reload();
    test_priority_pause();
    test_tick_gating();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
